mem_arbiter: RTL and testbench

Three-way arbiter and sequencer for the multicycle CPU's single-port unified instruction/data memory. It shares the memory between three requesters with a round-robin policy: instruction fetch, the data load/store path, and a debug/loader port. It registers each winning request, drives the memory control signals for exactly one access cycle, and returns read data one cycle later. It sits between the CPU control unit / debug logic and the memory.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between instruction
// fetch, the data path and a debug/loader port: one access every two cycles.
module mem_arbiter #(
  parameter int RAM_SIZE_BIT  = 8,
  parameter int RAM_INST_SIZE = 32,
  parameter int INST_PROTECT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_DBG} owner_t;

  localparam logic [RAM_SIZE_BIT:0] INST_LIMIT = RAM_INST_SIZE[RAM_SIZE_BIT:0];

  state_t      state_q, state_d;
  owner_t      last_q, last_d;
  owner_t      owner_q, owner_d;
  owner_t      win;
  logic        any_req;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        blocked;
  logic        if_rvalid_q, d_rvalid_q, dbg_rvalid_q;
  logic [31:0] if_rdata_q, d_rdata_q, dbg_rdata_q;

  // Search starts at the requester following the previous winner.
  function automatic owner_t rr_pick(input owner_t last, input logic r_if,
                                     input logic r_d, input logic r_dbg);
    owner_t pick;
    unique case (last)
      OWN_IF:  pick = r_d   ? OWN_D   : (r_dbg ? OWN_DBG : OWN_IF);
      OWN_D:   pick = r_dbg ? OWN_DBG : (r_if  ? OWN_IF  : OWN_D);
      default: pick = r_if  ? OWN_IF  : (r_d   ? OWN_D   : OWN_DBG);
    endcase
    return pick;
  endfunction

  assign any_req = if_req | d_req | dbg_req;
  assign win     = rr_pick(last_q, if_req, d_req, dbg_req);
  assign blocked = (INST_PROTECT != 0) && (owner_q == OWN_D) && we_q &&
                   ({1'b0, addr_q[RAM_SIZE_BIT+1:2]} < INST_LIMIT);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          last_d  = win;
          owner_d = win;
          unique case (win)
            OWN_IF: begin
              addr_d  = if_addr;
              wdata_d = '0;
              we_d    = 1'b0;
            end
            OWN_D: begin
              addr_d  = d_addr;
              wdata_d = d_wdata;
              we_d    = d_we;
            end
            default: begin
              addr_d  = dbg_addr;
              wdata_d = dbg_wdata;
              we_d    = dbg_we;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= OWN_DBG;
      owner_q <= OWN_DBG;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  // Latched request payload only matters while in ACCESS, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    we_q    <= we_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if (state_q == S_ACCESS && !we_q) begin
        unique case (owner_q)
          OWN_IF: begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
          OWN_D: begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= mem_rdata;
          end
          default: begin
            dbg_rvalid_q <= 1'b1;
            dbg_rdata_q  <= mem_rdata;
          end
        endcase
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    dbg_gnt   = 1'b0;
    d_err     = 1'b0;
    if (state_q == S_ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_read  = !we_q;
      mem_write = we_q && !blocked;
      if_gnt    = (owner_q == OWN_IF);
      d_gnt     = (owner_q == OWN_D);
      dbg_gnt   = (owner_q == OWN_DBG);
      d_err     = blocked;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-word memory attached.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:255];
  int total, bad;

  mem_arbiter #(.RAM_SIZE_BIT(8), .RAM_INST_SIZE(32), .INST_PROTECT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h3C08ABCD;
    mem[4]  = 32'hA5A5A5A5;
    mem[33] = 32'hCAFEF00D;
    forever begin
      @(posedge clk);
      if (mem_write === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs;
    if_req = 0; d_req = 0; d_we = 0; dbg_req = 0; dbg_we = 0;
  endtask

  task automatic do_reset;
    drop_reqs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset;
    reset = 0;
    #3;
    total++;
    if ({if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, d_err, mem_read, mem_write} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, d_err, mem_read, mem_write});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if ({if_rdata, d_rdata, dbg_rdata} !== 96'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h %h want 0", if_rdata, d_rdata, dbg_rdata);
    end
    tick();
    reset = 1;
  endtask

  task automatic test_single_fetch;
    if_req = 1; if_addr = 32'h0;
    tick();
    total++;
    if ({if_gnt, d_gnt, dbg_gnt, mem_read, mem_write} !== 5'b10010 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL fetch_gnt: got gnt/rd/wr=%b addr=%h want 10010 addr=0",
               {if_gnt, d_gnt, dbg_gnt, mem_read, mem_write}, mem_addr);
    end
    if_req = 0;
    tick();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h3C08ABCD || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL fetch_rvalid: got rvalid=%b rdata=%h gnt=%b want 1 3c08abcd 0",
               if_rvalid, if_rdata, if_gnt);
    end
    tick();
    total++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h3C08ABCD || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL fetch_hold: got rvalid=%b rdata=%h rd=%b want 0 3c08abcd 0",
               if_rvalid, if_rdata, mem_read);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] seq [3];
    logic [2:0] expg, expr;
    seq[0] = 3'b100; seq[1] = 3'b010; seq[2] = 3'b001;
    do_reset();
    if_req = 1;  if_addr = 32'h0;
    d_req = 1;   d_we = 0;   d_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h84;
    for (int k = 0; k < 12; k++) begin
      tick();
      expg = (k % 2 == 0) ? seq[(k / 2) % 3] : 3'b000;
      expr = (k % 2 == 1) ? seq[(k / 2) % 3] : 3'b000;
      total++;
      if ({if_gnt, d_gnt, dbg_gnt} !== expg || {if_rvalid, d_rvalid, dbg_rvalid} !== expr) begin
        bad++;
        $display("FAIL rr_cycle%0d: got gnt=%b rvalid=%b want gnt=%b rvalid=%b",
                 k, {if_gnt, d_gnt, dbg_gnt}, {if_rvalid, d_rvalid, dbg_rvalid}, expg, expr);
      end
    end
    drop_reqs();
    total++;
    if (d_rdata !== 32'hA5A5A5A5 || dbg_rdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL rr_rdata: got d=%h dbg=%h want a5a5a5a5 cafef00d", d_rdata, dbg_rdata);
    end
    tick();
  endtask

  task automatic test_write_readback;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
    tick();
    total++;
    if ({d_gnt, mem_write, mem_read, d_err} !== 4'b1100 || mem_addr !== 32'h80 ||
        mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_access: got gnt/wr/rd/err=%b addr=%h wdata=%h want 1100 80 deadbeef",
               {d_gnt, mem_write, mem_read, d_err}, mem_addr, mem_wdata);
    end
    drop_reqs();
    tick();
    total++;
    if (mem_write !== 1'b0 || d_rvalid !== 1'b0 || mem[32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_done: got wr=%b rvalid=%b mem=%h want 0 0 deadbeef",
               mem_write, d_rvalid, mem[32]);
    end
    d_req = 1; d_addr = 32'h80;
    tick();
    drop_reqs();
    tick();
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_back: got rvalid=%b rdata=%h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_protected_write;
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h11111111;
    tick();
    total++;
    if ({d_gnt, d_err, mem_write} !== 3'b110) begin
      bad++;
      $display("FAIL prot_access: got gnt/err/wr=%b want 110", {d_gnt, d_err, mem_write});
    end
    drop_reqs();
    tick();
    total++;
    if (mem[4] !== 32'hA5A5A5A5 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin
      bad++;
      $display("FAIL prot_mem: got mem=%h rvalid=%b err=%b want a5a5a5a5 0 0",
               mem[4], d_rvalid, d_err);
    end
  endtask

  task automatic test_debug_write;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'h02000005;
    tick();
    total++;
    if ({dbg_gnt, mem_write, d_err} !== 3'b110) begin
      bad++;
      $display("FAIL dbg_access: got gnt/wr/err=%b want 110", {dbg_gnt, mem_write, d_err});
    end
    drop_reqs();
    tick();
    if_req = 1; if_addr = 32'h10;
    tick();
    drop_reqs();
    tick();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h02000005) begin
      bad++;
      $display("FAIL dbg_readback: got rvalid=%b rdata=%h want 1 02000005", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_reset_mid_access;
    d_req = 1; d_we = 1; d_addr = 32'h84; d_wdata = 32'h12345678;
    tick();
    total++;
    if (mem_write !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got wr=%b want 1", mem_write);
    end
    #2 reset = 0;
    #1;
    total++;
    if ({mem_write, mem_read, if_gnt, d_gnt, dbg_gnt} !== 5'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL midrst_drop: got wr/rd/gnt=%b addr=%h want 00000 0",
               {mem_write, mem_read, if_gnt, d_gnt, dbg_gnt}, mem_addr);
    end
    drop_reqs();
    tick();
    total++;
    if (mem[33] !== 32'hCAFEF00D || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL midrst_mem: got mem=%h rvalid=%b rdata=%h want cafef00d 0 0",
               mem[33], d_rvalid, d_rdata);
    end
    reset = 1;
    if_req = 1;  if_addr = 32'h0;
    d_req = 1;   d_addr = 32'h80;
    dbg_req = 1; dbg_addr = 32'h84;
    tick();
    total++;
    if ({if_gnt, d_gnt, dbg_gnt} !== 3'b100) begin
      bad++;
      $display("FAIL post_rst_first: got gnt=%b want 100", {if_gnt, d_gnt, dbg_gnt});
    end
    drop_reqs();
    tick();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h3C08ABCD || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_read: got rvalid=%b rdata=%h d_rvalid=%b want 1 3c08abcd 0",
               if_rvalid, if_rdata, d_rvalid);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1;
    if_addr = 0; d_addr = 0; d_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    drop_reqs();
    #1;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_write_readback();
    test_protected_write();
    test_debug_write();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
